// File: rtl/reduce_pkg.sv
// ============================================================================
// Module   : reduce_pkg
// Brief    : Shared state encoding and default sizes for the reduce scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package reduce_pkg;

    localparam int c_ADDR_W = 4;
    localparam int c_DATA_W = 8;
    localparam int c_SUM_W  = 12;
    localparam int c_DEPTH  = 2 ** c_ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/reduce_accumulator.sv
// ============================================================================
// Module   : reduce_accumulator
// Brief    : Sum register with sticky carry-out; clear has priority over enable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reduce_accumulator #(
    parameter int DATA_W = 8,
    parameter int SUM_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_data,
    output logic [SUM_W-1:0]  o_acc,
    output logic              o_overflow
);

    logic [SUM_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [SUM_W:0]   w_sum;

    assign w_sum = {1'b0, acc_q} + {{(SUM_W + 1 - DATA_W){1'b0}}, i_data};

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (i_clear) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (i_en) begin
            acc_d = w_sum[SUM_W-1:0];
            ovf_d = ovf_q | w_sum[SUM_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign o_acc      = acc_q;
    assign o_overflow = ovf_q;

endmodule

`default_nettype wire

// File: rtl/reduce_scheduler.sv
// ============================================================================
// Module   : reduce_scheduler
// Brief    : Wrapping-window reduce-sum scan sharing a register file with a host
//            writer. REDUCE_WRITE_PRIORITY_EN lets host writes stall the scan.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reduce_scheduler
    import reduce_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W,
    parameter int SUM_W  = c_SUM_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_waddr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_grant,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  total,
    output logic              overflow
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [SUM_W-1:0]  total_q, total_d;

    logic              w_acc_clear;
    logic              w_acc_en;
    logic              w_grant;
    logic              w_stall;
    logic              w_pass;
    logic [SUM_W-1:0]  w_acc;
    logic              w_acc_ovf;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        total_d     = total_q;
        w_acc_clear = 1'b0;
        w_acc_en    = 1'b0;
        w_grant     = 1'b0;
        w_stall     = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy    = 1'b0;
                w_grant = host_we;
                if (start) begin
                    w_acc_clear = 1'b1;
                    if (count != '0) begin
                        ptr_d   = start_addr;
                        rem_d   = count;
                        state_d = ST_SCAN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_SCAN: begin
`ifdef REDUCE_WRITE_PRIORITY_EN
                w_grant = host_we;
                w_stall = host_we;
`endif
                if (!w_stall) begin
                    w_acc_en = 1'b1;
                    ptr_d    = ptr_q + 1'b1;
                    rem_d    = rem_q - 1'b1;
                    if (rem_q == (ADDR_W + 1)'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                total_d = w_acc;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write port is a pass-through; reset forces it quiet even though the FSM sits in IDLE.
    assign w_pass     = ((state_q == ST_IDLE) || w_grant) && !reset;
    assign host_grant = w_grant && !reset;
    assign mem_we     = host_grant;
    assign mem_waddr  = w_pass ? host_waddr : '0;
    assign mem_wdata  = w_pass ? host_wdata : '0;
    assign mem_raddr  = ptr_q;
    assign total      = total_q;
    assign overflow   = w_acc_ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            total_q <= total_d;
        end
    end

    reduce_accumulator #(
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W)
    ) u_acc (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_acc_clear),
        .i_en       (w_acc_en),
        .i_data     (mem_rdata),
        .o_acc      (w_acc),
        .o_overflow (w_acc_ovf)
    );

endmodule

`default_nettype wire

// File: tb/tb_reduce_scheduler.sv
// ============================================================================
// Module   : tb_reduce_scheduler
// Brief    : Scoreboard bench for reduce_scheduler (12-bit and 8-bit sum builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reduce_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  start_addr;
    logic [4:0]  count;
    logic        host_we;
    logic [3:0]  host_waddr;
    logic [7:0]  host_wdata;
    logic        host_grant;
    logic        mem_we;
    logic [3:0]  mem_waddr;
    logic [7:0]  mem_wdata;
    logic [3:0]  mem_raddr;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        done;
    logic [11:0] total;
    logic        overflow;

    logic        start2;
    logic [3:0]  start_addr2;
    logic [4:0]  count2;
    logic        host_we2;
    logic [3:0]  host_waddr2;
    logic [7:0]  host_wdata2;
    logic        host_grant2;
    logic        mem_we2;
    logic [3:0]  mem_waddr2;
    logic [7:0]  mem_wdata2;
    logic [3:0]  mem_raddr2;
    logic [7:0]  mem_rdata2;
    logic        busy2;
    logic        done2;
    logic [7:0]  total2;
    logic        overflow2;

    logic [7:0]  mem  [16];
    logic [7:0]  mem2 [16];

    typedef struct {
        int sum;
        bit ovf;
        int done_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t sb2[$];
    exp_t pe;
    exp_t pe2;
    bit   pend  = 1'b0;
    bit   pend2 = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int busy_cnt = 0;

`ifdef REDUCE_WRITE_PRIORITY_EN
    localparam bit c_PRIO = 1'b1;
`else
    localparam bit c_PRIO = 1'b0;
`endif

    always #5 clk = ~clk;

    reduce_scheduler u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .host_we    (host_we),
        .host_waddr (host_waddr),
        .host_wdata (host_wdata),
        .host_grant (host_grant),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .total      (total),
        .overflow   (overflow)
    );

    reduce_scheduler #(.SUM_W(8)) u_dut8 (
        .clk        (clk),
        .reset      (reset),
        .start      (start2),
        .start_addr (start_addr2),
        .count      (count2),
        .host_we    (host_we2),
        .host_waddr (host_waddr2),
        .host_wdata (host_wdata2),
        .host_grant (host_grant2),
        .mem_we     (mem_we2),
        .mem_waddr  (mem_waddr2),
        .mem_wdata  (mem_wdata2),
        .mem_raddr  (mem_raddr2),
        .mem_rdata  (mem_rdata2),
        .busy       (busy2),
        .done       (done2),
        .total      (total2),
        .overflow   (overflow2)
    );

    assign mem_rdata  = mem[mem_raddr];
    assign mem_rdata2 = mem2[mem_raddr2];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor for the 12-bit build: done timing, then result one cycle later.
    always @(negedge clk) begin
        if (!reset) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                chk("done_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    pe = sb.pop_front();
                    chk("done_cycle", cyc, pe.done_cyc);
                    pend = 1'b1;
                end
            end else if (pend) begin
                pend = 1'b0;
                chk("total", total, pe.sum);
                chk("overflow", overflow, pe.ovf);
                chk("busy_fall", busy, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (done2) begin
                chk("done2_expected", sb2.size() != 0, 1);
                if (sb2.size() != 0) begin
                    pe2   = sb2.pop_front();
                    pend2 = 1'b1;
                end
            end else if (pend2) begin
                pend2 = 1'b0;
                chk("total8", total2, pe2.sum);
                chk("overflow8", overflow2, pe2.ovf);
            end
        end
    end

    // Called one step after a rising edge; start is held for exactly that cycle.
    task automatic do_start(input logic [3:0] a, input logic [4:0] n,
                            input int sum, input bit ovf, input int lat);
        start      = 1'b1;
        start_addr = a;
        count      = n;
        sb.push_back('{sum, ovf, cyc + lat});
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic do_start2(input logic [4:0] n, input int sum, input bit ovf);
        start2      = 1'b1;
        start_addr2 = 4'd0;
        count2      = n;
        sb2.push_back('{sum, ovf, 0});
        @(posedge clk);
        #1 start2 = 1'b0;
    endtask

    task automatic wait_idle(input bit which);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!(which ? busy2 : busy)) begin
                ok = 1'b1;
                break;
            end
        end
        chk("scan_terminates", ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        host_we    = 1'b1;
        host_waddr = a;
        host_wdata = d;
        @(negedge clk);
        chk("idle_grant", host_grant, 1);
        chk("idle_mem_waddr", mem_waddr, a);
        @(posedge clk);
        #1 host_we = 1'b0;
        chk("idle_mem_data", mem[a], d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b0, d0, k, gc;
        for (int i = 0; i < 16; i++) begin
            mem[i]  = 8'(i + 1);
            mem2[i] = 8'hFF;
        end
        reset = 1'b1;
        start = 1'b0; start_addr = '0; count = '0;
        host_we = 1'b1; host_waddr = 4'd5; host_wdata = 8'hAA;
        start2 = 1'b0; start_addr2 = '0; count2 = '0;
        host_we2 = 1'b0; host_waddr2 = '0; host_wdata2 = '0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_total", total, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_raddr", mem_raddr, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_grant", host_grant, 0);
        host_we = 1'b0;
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        // Full window with a stray start mid-scan that must be dropped.
        b0 = busy_cnt; d0 = done_cnt;
        do_start(4'd0, 5'd16, 136, 1'b0, 17);
        repeat (3) @(posedge clk);
        #1 start = 1'b1; start_addr = 4'd5; count = 5'd3;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle(1'b0);
        chk("full_busy_cycles", busy_cnt - b0, 17);
        chk("full_done_pulses", done_cnt - d0, 1);

        b0 = busy_cnt;
        do_start(4'd14, 5'd4, 34, 1'b0, 5);
        wait_idle(1'b0);
        chk("wrap_busy_cycles", busy_cnt - b0, 5);

        b0 = busy_cnt;
        do_start(4'd7, 5'd0, 0, 1'b0, 1);
        wait_idle(1'b0);
        chk("zero_busy_cycles", busy_cnt - b0, 1);

        // Host write to address 3 while the full scan is running.
        k = cyc;
        do_start(4'd0, 5'd16, c_PRIO ? 387 : 136, 1'b0, c_PRIO ? 18 : 17);
        repeat (2) @(posedge clk);
        #1 host_we = 1'b1; host_waddr = 4'd3; host_wdata = 8'hFF;
        gc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (host_grant) begin
                gc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1 host_we = 1'b0;
        chk("scan_grant_cycle", gc - k, c_PRIO ? 3 : 18);
        wait_idle(1'b0);
        chk("scan_write_landed", mem[3], 8'hFF);
        host_write(4'd3, 8'd4);

        // Write and start in the same cycle: the scan sees the new word.
        host_we = 1'b1; host_waddr = 4'd0; host_wdata = 8'd100;
        do_start(4'd0, 5'd1, 100, 1'b0, 2);
        host_we = 1'b0;
        wait_idle(1'b0);
        host_write(4'd0, 8'd1);

        // Asynchronous reset in the middle of a scan.
        do_start(4'd0, 5'd16, 136, 1'b0, 17);
        repeat (4) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_total", total, 0);
        chk("abort_overflow", overflow, 0);
        sb.delete();
        pend = 1'b0;
        @(negedge clk) reset = 1'b0;
        d0 = done_cnt;
        repeat (25) @(posedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        #1;
        do_start(4'd0, 5'd16, 136, 1'b0, 17);
        wait_idle(1'b0);

        // 8-bit accumulator: carry-out is sticky, then cleared by a new scan.
        do_start2(5'd2, 8'hFE, 1'b1);
        wait_idle(1'b1);
        do_start2(5'd1, 8'hFF, 1'b0);
        wait_idle(1'b1);

        repeat (3) @(posedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("sb8_drained", sb2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
